wb_port_scheduler: RTL and testbench

Owns the single write port of the 32×32 register file and shares it between pipeline W-stage writeback and a multi-cycle mul/div unit (MDU). MDU results are buffered in a small FIFO and drained whenever the pipeline leaves the port idle. A per-register pending scoreboard raises a D-stage stall on RAW and WAW hazards against outstanding MDU results. A starvation counter forces pipeline bubbles so buffered results always drain.

---
 rtl/wb_port_scheduler.sv | 122 ++++++++++++
 tb/tb_wb_port_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_scheduler.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results queue in a
// small FIFO and drain on idle cycles; a pending scoreboard stalls D on hazards.
module wb_port_scheduler #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_D,
    input  logic        we_D,
    input  logic        mdu_op_D,
    output logic        stall_D,
    input  logic        pipe_we_W,
    input  logic [4:0]  pipe_rd_W,
    input  logic [31:0] pipe_wd_W,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_wd,
    output logic        mdu_ready,
    output logic        WE3_W,
    output logic [4:0]  A3_W,
    output logic [31:0] WD3_W,
    output logic [31:0] pending
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned BlkW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [BlkW-1:0] BlkMax  = BlkW'(STARVE_LIMIT);

    logic [4:0]      rd_mem_q [DEPTH];
    logic [31:0]     wd_mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
    logic [31:0]     pending_q, pending_d;

    logic        pipe_act, fifo_empty, push, pop, starve, accept;
    logic [4:0]  head_rd;
    logic [31:0] head_wd;

    assign pending = pending_q;

    always_comb begin
        pipe_act   = pipe_we_W & (pipe_rd_W != 5'd0);
        fifo_empty = (count_q == '0);
        head_rd    = rd_mem_q[rd_ptr_q];
        head_wd    = wd_mem_q[rd_ptr_q];
        mdu_ready  = !rst & (count_q < CntFull);
        push       = mdu_valid & mdu_ready;
        pop        = !rst & !pipe_act & !fifo_empty;
        starve     = (blk_cnt_q == BlkMax);

        stall_D = !rst & ((pending_q[rs1_D] & (rs1_D != 5'd0)) |
                          (pending_q[rs2_D] & (rs2_D != 5'd0)) |
                          (we_D & pending_q[rd_D] & (rd_D != 5'd0)) |
                          starve);
        accept  = !rst & mdu_op_D & we_D & !stall_D & (rd_D != 5'd0);

        WE3_W = 1'b0;
        A3_W  = 5'd0;
        WD3_W = 32'd0;
        if (!rst && pipe_act) begin
            WE3_W = 1'b1;
            A3_W  = pipe_rd_W;
            WD3_W = pipe_wd_W;
        end else if (pop && head_rd != 5'd0) begin
            // An x0 entry is still popped but never reaches the register file.
            WE3_W = 1'b1;
            A3_W  = head_rd;
            WD3_W = head_wd;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        if (push && !pop) count_d = count_q + CntW'(1);
        if (pop && !push) count_d = count_q - CntW'(1);

        pending_d = pending_q;
        if (accept) pending_d[rd_D] = 1'b1;
        if (pop) pending_d[head_rd] = 1'b0;
        pending_d[0] = 1'b0;

        blk_cnt_d = blk_cnt_q;
        if (pop || fifo_empty) blk_cnt_d = '0;
        else if (pipe_act && !starve) blk_cnt_d = blk_cnt_q + BlkW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            blk_cnt_q <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            blk_cnt_q <= blk_cnt_d;
            pending_q <= pending_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q] <= mdu_rd;
            wd_mem_q[wr_ptr_q] <= mdu_wd;
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: a cycle-by-cycle vector table followed by hand-written
// full-FIFO, starvation and mid-operation reset sequences.
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        we_D, mdu_op_D, stall_D;
    logic        pipe_we_W;
    logic [4:0]  pipe_rd_W;
    logic [31:0] pipe_wd_W;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wd;
    logic        WE3_W;
    logic [4:0]  A3_W;
    logic [31:0] WD3_W, pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .we_D(we_D), .mdu_op_D(mdu_op_D),
        .stall_D(stall_D),
        .pipe_we_W(pipe_we_W), .pipe_rd_W(pipe_rd_W), .pipe_wd_W(pipe_wd_W),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .WE3_W(WE3_W), .A3_W(A3_W), .WD3_W(WD3_W), .pending(pending)
    );

    typedef struct {
        string       name;
        logic        r;
        logic [4:0]  rs1, rs2, rd;
        logic        we, op, pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mwd;
        logic        e_stall, e_ready, e_we3;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3, e_pend;
    } vec_t;

    function automatic vec_t mk(string n, logic r, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic we, logic op, logic pwe,
                                logic [4:0] prd, logic [31:0] pwd, logic mv,
                                logic [4:0] mrd, logic [31:0] mwd, logic es, logic er,
                                logic ew, logic [4:0] ea, logic [31:0] ed, logic [31:0] ep);
        vec_t v;
        v.name = n; v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.op = op;
        v.pwe = pwe; v.prd = prd; v.pwd = pwd; v.mv = mv; v.mrd = mrd; v.mwd = mwd;
        v.e_stall = es; v.e_ready = er; v.e_we3 = ew; v.e_a3 = ea; v.e_wd3 = ed;
        v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; rs1_D = '0; rs2_D = '0; rd_D = '0; we_D = 1'b0; mdu_op_D = 1'b0;
        pipe_we_W = 1'b0; pipe_rd_W = '0; pipe_wd_W = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[24];

    initial begin
        // name       r rs1 rs2 rd we op pwe prd pwd     mv mrd mwd      stl rdy we3 a3 wd3 pend
        vecs[0]  = mk("rst_a",    1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 4, 1,       0, 0, 0, 0, 0, 0);
        vecs[1]  = mk("rst_b",    1, 0, 0, 0, 0, 0, 1, 3, 'hAA,    1, 4, 1,       0, 0, 0, 0, 0, 0);
        vecs[2]  = mk("released", 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[3]  = mk("issue5",   0, 0, 0, 5, 1, 1, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[4]  = mk("raw5",     0, 5, 0, 0, 0, 0, 0, 0, 0,       1, 5, 'h1234,  1, 1, 0, 0, 0, 'h20);
        vecs[5]  = mk("wr5",      0, 5, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 5, 'h1234, 'h20);
        vecs[6]  = mk("unstall5", 0, 5, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[7]  = mk("issue7",   0, 0, 0, 7, 1, 1, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[8]  = mk("prio_a",   0, 0, 0, 0, 0, 0, 1, 3, 'hAA,    1, 7, 'h77,    0, 1, 1, 3, 'hAA, 'h80);
        vecs[9]  = mk("prio_b",   0, 0, 0, 0, 0, 0, 1, 3, 'hBB,    0, 0, 0,       0, 1, 1, 3, 'hBB, 'h80);
        vecs[10] = mk("pipe_x0",  0, 0, 0, 0, 0, 0, 1, 0, 'hCC,    0, 0, 0,       0, 1, 1, 7, 'h77, 'h80);
        vecs[11] = mk("clr7",     0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[12] = mk("issue_x0", 0, 0, 0, 0, 1, 1, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[13] = mk("issue9",   0, 0, 0, 9, 1, 1, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[14] = mk("waw_mdu",  0, 0, 0, 9, 1, 1, 0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0, 'h200);
        vecs[15] = mk("waw_alu",  0, 0, 0, 9, 1, 0, 0, 0, 0,       0, 0, 0,       1, 1, 0, 0, 0, 'h200);
        vecs[16] = mk("res9",     0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 9, 9,       0, 1, 0, 0, 0, 'h200);
        vecs[17] = mk("wr9",      0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 1, 9, 9, 'h200);
        vecs[18] = mk("clr9",     0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[19] = mk("res_x0",   0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 0, 'h55,    0, 1, 0, 0, 0, 0);
        vecs[20] = mk("pop_x0",   0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);
        vecs[21] = mk("res12",    0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 12, 'hC,    0, 1, 0, 0, 0, 0);
        vecs[22] = mk("wr12",     0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 1, 12, 'hC, 0);
        vecs[23] = mk("empty",    0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 0, 0);

        idle_in();
        rst = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            rst = vecs[i].r; rs1_D = vecs[i].rs1; rs2_D = vecs[i].rs2; rd_D = vecs[i].rd;
            we_D = vecs[i].we; mdu_op_D = vecs[i].op;
            pipe_we_W = vecs[i].pwe; pipe_rd_W = vecs[i].prd; pipe_wd_W = vecs[i].pwd;
            mdu_valid = vecs[i].mv; mdu_rd = vecs[i].mrd; mdu_wd = vecs[i].mwd;
            @(negedge clk);
            chk({vecs[i].name, ".stall"}, 32'(stall_D), 32'(vecs[i].e_stall));
            chk({vecs[i].name, ".ready"}, 32'(mdu_ready), 32'(vecs[i].e_ready));
            chk({vecs[i].name, ".we3"}, 32'(WE3_W), 32'(vecs[i].e_we3));
            chk({vecs[i].name, ".a3"}, 32'(A3_W), 32'(vecs[i].e_a3));
            chk({vecs[i].name, ".wd3"}, WD3_W, vecs[i].e_wd3);
            chk({vecs[i].name, ".pending"}, pending, vecs[i].e_pend);
            next_cycle();
        end

        // Fill the FIFO behind a busy pipeline, then drain; push and pop coincide at count 1.
        idle_in();
        pipe_we_W = 1'b1; pipe_rd_W = 5'd1; pipe_wd_W = 32'd1;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_wd = 32'hA0;
        @(negedge clk); chk("full.rdy0", 32'(mdu_ready), 1); next_cycle();
        mdu_rd = 5'd11; mdu_wd = 32'hB0;
        @(negedge clk); chk("full.rdy1", 32'(mdu_ready), 1); chk("full.pipe_a3", 32'(A3_W), 1);
        next_cycle();
        mdu_rd = 5'd13; mdu_wd = 32'hD0;
        @(negedge clk); chk("full.rdy2", 32'(mdu_ready), 0); next_cycle();
        pipe_we_W = 1'b0;
        @(negedge clk);
        chk("full.no_bypass", 32'(mdu_ready), 0);
        chk("full.pop10_a3", 32'(A3_W), 10); chk("full.pop10_wd", WD3_W, 32'hA0);
        next_cycle();
        @(negedge clk);
        chk("full.pushpop_rdy", 32'(mdu_ready), 1);
        chk("full.pop11_a3", 32'(A3_W), 11); chk("full.pop11_wd", WD3_W, 32'hB0);
        next_cycle();
        mdu_valid = 1'b0;
        @(negedge clk);
        chk("full.pop13_we", 32'(WE3_W), 1);
        chk("full.pop13_a3", 32'(A3_W), 13); chk("full.pop13_wd", WD3_W, 32'hD0);
        next_cycle();
        @(negedge clk); chk("full.drained", 32'(WE3_W), 0); next_cycle();

        // Starvation: one buffered result blocked by a continuously writing pipeline.
        idle_in();
        pipe_we_W = 1'b1; pipe_rd_W = 5'd2; pipe_wd_W = 32'h2;
        mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_wd = 32'hE0;
        @(negedge clk); chk("starve.push", 32'(stall_D), 0); next_cycle();
        mdu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); chk($sformatf("starve.pre%0d", i), 32'(stall_D), 0); next_cycle();
        end
        @(negedge clk);
        chk("starve.on", 32'(stall_D), 1); chk("starve.pipe_a3", 32'(A3_W), 2);
        next_cycle();
        @(negedge clk); chk("starve.hold", 32'(stall_D), 1); next_cycle();
        pipe_we_W = 1'b0;
        @(negedge clk);
        chk("starve.pop_cycle", 32'(stall_D), 1); chk("starve.pop_a3", 32'(A3_W), 14);
        next_cycle();
        @(negedge clk);
        chk("starve.off", 32'(stall_D), 0); chk("starve.empty_we", 32'(WE3_W), 0);
        next_cycle();

        // Reset with a buffered result and a pending bit outstanding.
        idle_in();
        we_D = 1'b1; mdu_op_D = 1'b1; rd_D = 5'd15;
        pipe_we_W = 1'b1; pipe_rd_W = 5'd2;
        mdu_valid = 1'b1; mdu_rd = 5'd15; mdu_wd = 32'hF0;
        @(negedge clk); chk("mr.issue", 32'(stall_D), 0); next_cycle();
        idle_in();
        pipe_we_W = 1'b1; pipe_rd_W = 5'd2; rs1_D = 5'd15;
        @(negedge clk);
        chk("mr.pend", pending, 32'h8000); chk("mr.stall", 32'(stall_D), 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mr.rst_we3", 32'(WE3_W), 0); chk("mr.rst_ready", 32'(mdu_ready), 0);
        chk("mr.rst_stall", 32'(stall_D), 0);
        next_cycle();
        rst = 1'b0; pipe_we_W = 1'b0;
        @(negedge clk);
        chk("mr.pend_clr", pending, 0); chk("mr.flushed", 32'(WE3_W), 0);
        chk("mr.stall_clr", 32'(stall_D), 0); chk("mr.ready", 32'(mdu_ready), 1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
